// File: rtl/mem_stage.sv
// MIPS MEM stage: byte/half/word loads and stores on a word-organised data
// memory, with alignment checking and the MEM/WB pipeline register.
module mem_stage #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 32,
    parameter int NB_REG      = 5,
    parameter int MEM_DEPTH   = 256,
    parameter int NB_MEM_ADDR = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [NB_ADDR-1:0]     i_alu_result,
    input  logic [NB_DATA-1:0]     i_write_data,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic                   i_mem_to_reg,
    input  logic                   i_reg_write,
    input  logic [NB_REG-1:0]      i_rd,
    input  logic [NB_MEM_ADDR-1:0] i_debug_addr,
    output logic [NB_DATA-1:0]     o_data_alu,
    output logic [NB_DATA-1:0]     o_data_mem,
    output logic                   o_selector,
    output logic                   o_reg_write,
    output logic [NB_REG-1:0]      o_rd,
    output logic                   o_misaligned,
    output logic [NB_DATA-1:0]     o_debug_data
);

    logic [NB_DATA-1:0] mem [MEM_DEPTH];

    logic [NB_MEM_ADDR-1:0] word_idx;
    logic [1:0]             lane;
    logic                   misaligned;
    logic                   fault;
    logic                   is_load;
    logic                   do_write;
    logic [3:0]             byte_en;
    logic [NB_DATA-1:0]     wr_data;
    logic [NB_DATA-1:0]     rd_word;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [NB_DATA-1:0]     load_data;

    // Address bits above the memory size are ignored so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_alu_result[NB_ADDR-1:NB_MEM_ADDR+2];

    // Address decode, alignment check and store byte enables.
    always_comb begin
        word_idx = i_alu_result[NB_MEM_ADDR+1:2];
        lane     = i_alu_result[1:0];
        case (i_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            default: misaligned = |lane;
        endcase
        fault    = (i_mem_read | i_mem_write) & misaligned;
        // A simultaneous read+write is treated as a store only.
        is_load  = i_mem_read & ~i_mem_write;
        do_write = i_enable & i_mem_write & ~misaligned;
        case (i_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{i_write_data[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_write_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = i_write_data;
            end
        endcase
    end

    // Combinational read, lane select and sign/zero extension.
    always_comb begin
        rd_word   = mem[word_idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        if (is_load && !misaligned) begin
            case (i_size)
                2'b00:   load_data = {{24{~i_unsigned & rd_byte[7]}}, rd_byte};
                2'b01:   load_data = {{16{~i_unsigned & rd_half[15]}}, rd_half};
                default: load_data = rd_word;
            endcase
        end
    end

    // Data memory with per-byte write enables; contents survive reset,
    // and a store that meets an asserted reset at the edge is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset && do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // MEM/WB pipeline register plus the always-running debug read port.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_data_alu   <= '0;
            o_data_mem   <= '0;
            o_selector   <= 1'b0;
            o_reg_write  <= 1'b0;
            o_rd         <= '0;
            o_misaligned <= 1'b0;
            o_debug_data <= '0;
        end else begin
            o_debug_data <= mem[i_debug_addr];
            if (i_enable) begin
                o_data_alu   <= i_alu_result[NB_DATA-1:0];
                o_data_mem   <= load_data;
                o_selector   <= i_mem_to_reg;
                o_reg_write  <= i_reg_write & ~(is_load & misaligned);
                o_rd         <= i_rd;
                o_misaligned <= fault;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps plus random traffic
// checked against a byte-addressed reference memory.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        mrd;
    logic        mwr;
    logic [1:0]  sz;
    logic        uns;
    logic        m2r;
    logic        rw;
    logic [4:0]  rdi;
    logic [7:0]  dbg;
    logic [31:0] o_data_alu;
    logic [31:0] o_data_mem;
    logic        o_selector;
    logic        o_reg_write;
    logic [4:0]  o_rd;
    logic        o_misaligned;
    logic [31:0] o_debug_data;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference state: byte-addressed memory and the expected WB fields.
    logic [7:0]  mb [1024];
    logic [31:0] e_alu, e_mem, e_dbg;
    logic        e_sel, e_rw, e_mis;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    mem_stage dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_enable     (en),
        .i_alu_result (alu),
        .i_write_data (wd),
        .i_mem_read   (mrd),
        .i_mem_write  (mwr),
        .i_size       (sz),
        .i_unsigned   (uns),
        .i_mem_to_reg (m2r),
        .i_reg_write  (rw),
        .i_rd         (rdi),
        .i_debug_addr (dbg),
        .o_data_alu   (o_data_alu),
        .o_data_mem   (o_data_mem),
        .o_selector   (o_selector),
        .o_reg_write  (o_reg_write),
        .o_rd         (o_rd),
        .o_misaligned (o_misaligned),
        .o_debug_data (o_debug_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        int b;
        b = a & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    function automatic logic [31:0] mload(input int a, input int n, input logic u);
        logic [7:0]  v8;
        logic [15:0] v16;
        if (n == 1) begin
            v8 = mb[a];
            return u ? 32'(v8) : 32'($signed(v8));
        end else if (n == 2) begin
            v16 = {mb[a+1], mb[a]};
            return u ? 32'(v16) : 32'($signed(v16));
        end
        return mword(a);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".alu"}, o_data_alu,   e_alu);
        chk({tag, ".mem"}, o_data_mem,   e_mem);
        chk({tag, ".sel"}, 32'(o_selector),   32'(e_sel));
        chk({tag, ".rw"},  32'(o_reg_write),  32'(e_rw));
        chk({tag, ".rd"},  32'(o_rd),         32'(e_rd));
        chk({tag, ".mis"}, 32'(o_misaligned), 32'(e_mis));
        chk({tag, ".dbg"}, o_debug_data, e_dbg);
    endtask

    // One pipeline cycle: drive, predict from the reference, clock, compare.
    task automatic step(input string tag, input logic en_i, input logic [31:0] alu_i,
                        input logic [31:0] wd_i, input logic rd_i, input logic wr_i,
                        input logic [1:0] sz_i, input logic uns_i, input logic m2r_i,
                        input logic rw_i, input logic [4:0] rdi_i, input logic [7:0] dbg_i);
        int a, n;
        logic mis;
        en = en_i; alu = alu_i; wd = wd_i; mrd = rd_i; mwr = wr_i; sz = sz_i;
        uns = uns_i; m2r = m2r_i; rw = rw_i; rdi = rdi_i; dbg = dbg_i;
        a   = int'(alu_i[9:0]);
        n   = (sz_i == 2'b00) ? 1 : (sz_i == 2'b01) ? 2 : 4;
        mis = (a % n) != 0;
        e_dbg = mword(4 * int'(dbg_i));
        if (en_i) begin
            e_alu = alu_i;
            e_sel = m2r_i;
            e_rd  = rdi_i;
            e_mis = (rd_i || wr_i) && mis;
            e_mem = 32'h0;
            e_rw  = rw_i;
            if (rd_i && !wr_i) begin
                if (mis) e_rw = 1'b0;
                else     e_mem = mload(a, n, uns_i);
            end
            if (wr_i && !mis)
                for (int i = 0; i < n; i++) mb[a+i] = wd_i[8*i +: 8];
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_expect();
        e_alu = 0; e_mem = 0; e_sel = 0; e_rw = 0; e_rd = 0; e_mis = 0; e_dbg = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; alu = 0; wd = 0; mrd = 0; mwr = 0; sz = 0; uns = 0;
        m2r = 0; rw = 0; rdi = 0; dbg = 0;
        clear_expect();
        #1;
        check_all("reset0");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Give every word a known value so the reference model is exact.
        for (int i = 0; i < 256; i++)
            step("init", 1, 32'(4 * i), 32'h0, 0, 1, 2'b11, 0, 0, 0, 5'd0, 8'(i));

        step("pass10", 1, 32'h10, 0, 0, 0, 2'b11, 0, 0, 1, 5'd3, 0);
        chk("pass10.lit", o_data_alu, 32'h10);

        // Word store then load from the same address.
        step("sw40", 1, 32'h40, 32'hDEADBEEF, 0, 1, 2'b11, 0, 0, 0, 5'd0, 8'h10);
        step("lw40", 1, 32'h40, 0, 1, 0, 2'b11, 0, 1, 1, 5'd8, 8'h10);
        chk("lw40.lit", o_data_mem, 32'hDEADBEEF);
        chk("lw40.sel", 32'(o_selector), 32'd1);
        chk("lw40.dbg", o_debug_data, 32'hDEADBEEF);

        step("lb41",  1, 32'h41, 0, 1, 0, 2'b00, 0, 1, 1, 5'd9, 8'h10);
        chk("lb41.lit", o_data_mem, 32'hFFFFFFBE);
        step("lbu41", 1, 32'h41, 0, 1, 0, 2'b00, 1, 1, 1, 5'd9, 8'h10);
        chk("lbu41.lit", o_data_mem, 32'h000000BE);
        step("lh42",  1, 32'h42, 0, 1, 0, 2'b01, 0, 1, 1, 5'd9, 8'h10);
        chk("lh42.lit", o_data_mem, 32'hFFFFDEAD);
        step("lhu42", 1, 32'h42, 0, 1, 0, 2'b01, 1, 1, 1, 5'd9, 8'h10);
        chk("lhu42.lit", o_data_mem, 32'h0000DEAD);

        // Partial stores touch only their lanes.
        step("sb43", 1, 32'h43, 32'hAAAAAA11, 0, 1, 2'b00, 0, 0, 0, 5'd0, 8'h10);
        step("lw40b", 1, 32'h40, 0, 1, 0, 2'b11, 0, 1, 1, 5'd1, 8'h10);
        chk("lw40b.lit", o_data_mem, 32'h11ADBEEF);
        step("sh40", 1, 32'h40, 32'h55552233, 0, 1, 2'b01, 0, 0, 0, 5'd0, 8'h10);
        step("lw40c", 1, 32'h40, 0, 1, 0, 2'b10, 0, 1, 1, 5'd1, 8'h10);
        chk("lw40c.lit", o_data_mem, 32'h11AD2233);

        // Misaligned store and load.
        step("sw41", 1, 32'h41, 32'h12345678, 0, 1, 2'b11, 0, 0, 0, 5'd0, 8'h10);
        chk("sw41.lit", 32'(o_misaligned), 32'd1);
        step("lh43", 1, 32'h43, 0, 1, 0, 2'b01, 0, 1, 1, 5'd4, 8'h10);
        chk("lh43.mem", o_data_mem, 32'h0);
        chk("lh43.rw", 32'(o_reg_write), 32'd0);
        chk("lh43.dbg", o_debug_data, 32'h11AD2233);

        // Stall with a store pending: no write, outputs hold.
        step("stall", 0, 32'h40, 32'hCAFEF00D, 0, 1, 2'b11, 0, 0, 1, 5'd7, 8'h10);
        step("stall2", 0, 32'h40, 32'hCAFEF00D, 0, 1, 2'b11, 0, 0, 1, 5'd7, 8'h10);
        chk("stall.dbg", o_debug_data, 32'h11AD2233);

        // Address wrap: 0x400 lands on word 0.
        step("sw400", 1, 32'h400, 32'h5, 0, 1, 2'b11, 0, 0, 0, 5'd0, 8'h0);
        step("dbg0", 1, 32'h0, 0, 0, 0, 2'b11, 0, 0, 0, 5'd0, 8'h0);
        chk("wrap.lit", o_debug_data, 32'h5);

        // Store then load with both read and write raised.
        step("rdwr", 1, 32'h84, 32'h0BADCAFE, 1, 1, 2'b11, 0, 1, 1, 5'd2, 8'h21);
        chk("rdwr.mem", o_data_mem, 32'h0);

        // Asynchronous reset in the middle of a cycle.
        step("prereset", 1, 32'h77, 0, 0, 0, 2'b11, 0, 1, 1, 5'd31, 8'h21);
        #2 rst_n = 1'b0;
        #1;
        clear_expect();
        check_all("async_rst");
        #1 rst_n = 1'b1;
        step("post_rst", 1, 32'h10, 0, 0, 0, 2'b11, 0, 0, 1, 5'd1, 8'h21);
        chk("post_rst.lit", o_data_alu, 32'h10);

        // Random traffic, mostly in a small address window to force reuse.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = {$urandom_range(0, 7) == 0 ? ra[31:6] : 26'h0, ra[5:0]};
            step("rand", $urandom_range(0, 9) != 0, ra, $urandom,
                 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline; sits between EX and WB.
- Consumes the ALU result, store data and control bits from EX. Performs byte, halfword and word loads/stores on an internal word-organised data memory.
- Registers everything WB needs: ALU result, load data, mem-to-reg selector, destination register and reg-write enable. This is the MEM/WB pipeline register.
- Provides a registered debug read port into data memory.

Parameters:
- NB_DATA, 32, data/word width.
- NB_ADDR, 32, address width from EX.
- NB_REG, 5, register index width.
- MEM_DEPTH, 256, number of 32-bit words in data memory.
- NB_MEM_ADDR, 8, word-index width; must equal log2(MEM_DEPTH).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  pipeline advance; 0 = stall.
- i_alu_result  in  NB_ADDR  ALU result; also the byte address for loads/stores.
- i_write_data  in  NB_DATA  store data (rt value).
- i_mem_read  in  1  load instruction.
- i_mem_write  in  1  store instruction.
- i_size  in  2  access size: 00 byte, 01 half, 11 word; 10 treated as word.
- i_unsigned  in  1  zero-extend load (LBU/LHU); 0 = sign-extend.
- i_mem_to_reg  in  1  WB mux selector passthrough.
- i_reg_write  in  1  register-file write enable passthrough.
- i_rd  in  NB_REG  destination register passthrough.
- i_debug_addr  in  NB_MEM_ADDR  debug word index.
- o_data_alu  out  NB_DATA  registered ALU result to WB.
- o_data_mem  out  NB_DATA  registered, extended load data to WB.
- o_selector  out  1  registered i_mem_to_reg.
- o_reg_write  out  1  registered reg-write enable; forced 0 on a misaligned load.
- o_rd  out  NB_REG  registered destination register.
- o_misaligned  out  1  registered alignment-fault flag for the instruction now in WB.
- o_debug_data  out  NB_DATA  registered memory word at i_debug_addr.

Behaviour:
- Reset (i_reset=0, asynchronous): all o_* outputs clear to 0 immediately. Memory contents are not reset. Reset asserted mid-store: the store is dropped if the edge has not yet occurred.
- Addressing:
  - Word index = i_alu_result[NB_MEM_ADDR+1:2]; upper address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH.
  - Byte lane = i_alu_result[1:0], little-endian (lane 0 = bits 7:0).
- Alignment fault:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - A misaligned store writes nothing.
  - A misaligned load gives o_data_mem=0 and o_reg_write=0.
  - o_misaligned=1 in both cases.
- Store, on the edge with i_enable=1, i_mem_write=1 and aligned:
  - Byte writes i_write_data[7:0] to the addressed lane only.
  - Half writes i_write_data[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - Word writes all 4 lanes.
  - Other lanes are unchanged (per-byte write enables).
- Load data path:
  - The word is read and the lane selected combinationally, then captured into o_data_mem on the enable edge. Latency is 1 cycle, the same as every other MEM/WB field.
  - Byte: bits [7:0] of the result come from the lane; the upper bits are sign- or zero-extended per i_unsigned.
  - Half: same rule applied to the 16-bit half.
  - Word: passed unchanged.
- Non-load cycles: o_data_mem=0.
- i_mem_read and i_mem_write both 1: the store executes, load data is 0, and o_misaligned is evaluated for the store.
- Store followed by load to the same address on the next cycle: the load returns the new data (the write completed at the earlier edge).
- Stall (i_enable=0): no memory write; all MEM/WB outputs hold their values.
- Debug port: o_debug_data <= mem[i_debug_addr] every edge, independent of i_enable; reflects writes from earlier edges.

Test Plan:
- Reset: drive i_reset=0 mid-cycle -> all outputs 0 asynchronously; after release with i_enable=1, ALU result 0x0000_0010 passes through -> o_data_alu=0x10 one cycle later.
- Word store/load: SW 0xDEADBEEF @0x40, next cycle LW @0x40 -> o_data_mem=0xDEADBEEF, o_selector=1; debug_addr=0x10 -> o_debug_data=0xDEADBEEF.
- Byte/half extension: after the word above:
  - LB @0x41 -> 0xFFFFFFBE.
  - LBU @0x41 -> 0x000000BE.
  - LH @0x42 -> 0xFFFFDEAD.
  - LHU @0x42 -> 0x0000DEAD.
- Partial store: SB 0x11 @0x43, then LW @0x40 -> 0x11ADBEEF; SH 0x2233 @0x40, then LW -> 0x11AD2233.
- Misaligned:
  - SW @0x41 -> memory unchanged, o_misaligned=1.
  - LH @0x43 -> o_data_mem=0, o_reg_write=0, o_misaligned=1.
- Stall and wrap:
  - Hold i_enable=0 with SW asserted -> outputs frozen, no write (debug read unchanged).
  - SW 0x5 @0x400 (MEM_DEPTH=256) -> the write lands at word 0 (debug_addr=0 reads 0x5).
